// File: rtl/nw_systolic_scorer.sv
// rtl/nw_systolic_scorer.sv - linear systolic Needleman-Wunsch global alignment scorer
// PE[k] holds query char s1[k] and produces row k+1 of H as target chars stream through.
module nw_systolic_scorer #(
   parameter int PE_COUNT = 8,
   parameter int CWIDTH   = 2,
   parameter int SWIDTH   = 16,
   parameter int LWIDTH   = 16,
   parameter int MATCH    = 1,
   parameter int MISMATCH = -1,
   parameter int INDEL    = -1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic [$clog2(PE_COUNT+1)-1:0]      len1,
   input  logic [LWIDTH-1:0]                  len2,
   input  logic                               q_valid,
   output logic                               q_ready,
   input  logic [CWIDTH-1:0]                  q_char,
   input  logic                               t_valid,
   output logic                               t_ready,
   input  logic [CWIDTH-1:0]                  t_char,
   output logic                               busy,
   output logic signed [SWIDTH-1:0]           score,
   output logic                               score_valid,
   output logic                               err
);
   localparam int L1W = $clog2(PE_COUNT+1);
   localparam int PIW = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1;
   localparam logic signed [SWIDTH-1:0] S_MATCH    = SWIDTH'(MATCH);
   localparam logic signed [SWIDTH-1:0] S_MISMATCH = SWIDTH'(MISMATCH);
   localparam logic signed [SWIDTH-1:0] S_INDEL    = SWIDTH'(INDEL);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                    state_q, state_d;
   logic [L1W-1:0]            len1_q, len1_d, qcnt_q, qcnt_d, dcnt_q, dcnt_d;
   logic [LWIDTH-1:0]         len2_q, len2_d, tcnt_q, tcnt_d;
   logic signed [SWIDTH-1:0]  score_q, score_d, zsum;
   logic                      err_q, err_d;
   logic                      start_ok, load_hs, acc, step;

   logic [CWIDTH-1:0]         c_q    [PE_COUNT];
   logic signed [SWIDTH-1:0]  h_q    [PE_COUNT];
   logic signed [SWIDTH-1:0]  diag_q [PE_COUNT];
   logic [CWIDTH-1:0]         tc_q   [PE_COUNT-1];
   logic [PE_COUNT-2:0]       v_q;
   logic signed [SWIDTH-1:0]  top_q;

   logic [CWIDTH-1:0]         cin_c [PE_COUNT];
   logic signed [SWIDTH-1:0]  ain_c [PE_COUNT];
   logic signed [SWIDTH-1:0]  nh_c  [PE_COUNT];
   logic [PE_COUNT-1:0]       vin_c;

   function automatic logic signed [SWIDTH-1:0] max3(input logic signed [SWIDTH-1:0] a,
                                                    input logic signed [SWIDTH-1:0] b,
                                                    input logic signed [SWIDTH-1:0] c);
      logic signed [SWIDTH-1:0] m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // PE[0] takes the streamed char and the top boundary H[0][j]; later PEs take the previous stage
   always_comb begin
      cin_c[0] = t_char;
      ain_c[0] = top_q + S_INDEL;
      vin_c[0] = acc;
      for (int k = 1; k < PE_COUNT; k++) begin
         cin_c[k] = tc_q[k-1];
         ain_c[k] = h_q[k-1];
         vin_c[k] = v_q[k-1];
      end
      for (int k = 0; k < PE_COUNT; k++) begin
         nh_c[k] = max3(diag_q[k] + ((c_q[k] == cin_c[k]) ? S_MATCH : S_MISMATCH),
                        ain_c[k] + S_INDEL, h_q[k] + S_INDEL);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         top_q <= '0;
         v_q   <= '0;
         for (int k = 0; k < PE_COUNT; k++) begin
            c_q[k]    <= '0;
            h_q[k]    <= '0;
            diag_q[k] <= '0;
         end
         for (int k = 0; k < PE_COUNT-1; k++) tc_q[k] <= '0;
      end else if (start_ok) begin
         top_q <= '0;
         v_q   <= '0;
      end else if (load_hs) begin
         for (int k = 0; k < PE_COUNT; k++) begin
            if (qcnt_q == L1W'(k)) begin
               c_q[k]    <= q_char;
               h_q[k]    <= SWIDTH'((k+1)*INDEL);
               diag_q[k] <= SWIDTH'(k*INDEL);
            end
         end
      end else if (step) begin
         if (acc) top_q <= top_q + S_INDEL;
         for (int k = 0; k < PE_COUNT; k++) begin
            if (vin_c[k]) begin
               h_q[k]    <= nh_c[k];
               diag_q[k] <= ain_c[k];
            end
         end
         for (int k = 0; k < PE_COUNT-1; k++) begin
            v_q[k] <= vin_c[k];
            if (vin_c[k]) tc_q[k] <= cin_c[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         len1_q  <= '0;
         len2_q  <= '0;
         qcnt_q  <= '0;
         tcnt_q  <= '0;
         dcnt_q  <= '0;
         score_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len1_q  <= len1_d;
         len2_q  <= len2_d;
         qcnt_q  <= qcnt_d;
         tcnt_q  <= tcnt_d;
         dcnt_q  <= dcnt_d;
         score_q <= score_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      len1_d      = len1_q;
      len2_d      = len2_q;
      qcnt_d      = qcnt_q;
      tcnt_d      = tcnt_q;
      dcnt_d      = dcnt_q;
      score_d     = score_q;
      err_d       = err_q;
      start_ok    = 1'b0;
      load_hs     = 1'b0;
      acc         = 1'b0;
      step        = 1'b0;
      q_ready     = 1'b0;
      t_ready     = 1'b0;
      busy        = 1'b0;
      score_valid = 1'b0;
      zsum        = SWIDTH'(len1) + SWIDTH'(len2);
      case (state_q)
         S_IDLE, S_DONE: begin
            score_valid = (state_q == S_DONE);
            if (start) begin
               start_ok = 1'b1;
               len1_d   = len1;
               len2_d   = len2;
               err_d    = 1'b0;
               qcnt_d   = '0;
               tcnt_d   = '0;
               dcnt_d   = '0;
               if (len1 > L1W'(PE_COUNT)) begin
                  err_d   = 1'b1;
                  score_d = '0;
                  state_d = S_DONE;
               end else if (len1 == '0 || len2 == '0) begin
                  score_d = zsum * S_INDEL;
                  state_d = S_DONE;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            busy    = 1'b1;
            q_ready = 1'b1;
            if (q_valid) begin
               load_hs = 1'b1;
               qcnt_d  = qcnt_q + 1'b1;
               if (qcnt_q == len1_q - 1'b1) state_d = S_RUN;
            end
         end
         S_RUN: begin
            busy    = 1'b1;
            t_ready = 1'b1;
            if (t_valid) begin
               acc    = 1'b1;
               step   = 1'b1;
               tcnt_d = tcnt_q + 1'b1;
               if (tcnt_q == len2_q - 1'b1) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // the last column needs len1-1 more steps to reach PE[len1-1]
            busy   = 1'b1;
            step   = 1'b1;
            dcnt_d = dcnt_q + 1'b1;
            if (dcnt_q == len1_q - 1'b1) begin
               score_d = h_q[PIW'(len1_q - 1'b1)];
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign score = score_q;
   assign err   = err_q;
endmodule

// File: tb/tb_nw_systolic_scorer.sv
// tb/tb_nw_systolic_scorer.sv - scoreboard bench for nw_systolic_scorer
module tb_nw_systolic_scorer;
   logic               clk = 1'b0;
   logic               rst_n;
   logic               start = 1'b0;
   logic [3:0]         len1 = '0;
   logic [15:0]        len2 = '0;
   logic               q_valid = 1'b0;
   logic               q_ready;
   logic [1:0]         q_char = '0;
   logic               t_valid = 1'b0;
   logic               t_ready;
   logic [1:0]         t_char = '0;
   logic               busy;
   logic signed [15:0] score;
   logic               score_valid;
   logic               err;

   int ncomp = 0;
   int nfail = 0;
   logic signed [15:0] exp_s[$];
   logic               exp_e[$];

   always #5 clk = ~clk;

   nw_systolic_scorer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len1(len1), .len2(len2),
      .q_valid(q_valid), .q_ready(q_ready), .q_char(q_char),
      .t_valid(t_valid), .t_ready(t_ready), .t_char(t_char),
      .busy(busy), .score(score), .score_valid(score_valid), .err(err)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
      ncomp++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic int model(input int l1, input int l2, input logic [1:0] a[32], input logic [1:0] b[32]);
      int h[33][65];
      int d, u, l, m;
      for (int i = 0; i <= l1; i++) h[i][0] = -i;
      for (int j = 0; j <= l2; j++) h[0][j] = -j;
      for (int i = 1; i <= l1; i++)
         for (int j = 1; j <= l2; j++) begin
            d = h[i-1][j-1] + ((a[i-1] == b[j-1]) ? 1 : -1);
            u = h[i-1][j] - 1;
            l = h[i][j-1] - 1;
            m = (d > u) ? d : u;
            h[i][j] = (m > l) ? m : l;
         end
      return h[l1][l2];
   endfunction

   task automatic run_job(input string name, input int l1, input int l2,
                          input logic [1:0] a[32], input logic [1:0] b[32],
                          input bit stall, input bit poke);
      int up, last_t, nq, nt;
      bit ee, norm;
      ee   = (l1 > 8);
      norm = !ee && l1 != 0 && l2 != 0;
      exp_e.push_back(ee);
      exp_s.push_back(ee ? 16'sd0 : 16'(model(l1, l2, a, b)));
      len1  = 4'(l1);
      len2  = 16'(l2);
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      up     = 1;
      last_t = 0;
      nq     = 0;
      nt     = 0;
      while (!score_valid && up < 3000) begin
         if (poke && up == 3) begin
            start = 1'b1;
            len1  = 4'd9;
         end else begin
            start = 1'b0;
         end
         q_valid = stall ? (up % 2 == 0) : 1'b1;
         q_char  = (nq < l1 && nq < 32) ? a[nq] : 2'($urandom);
         t_valid = stall ? (up % 3 == 1) : 1'b1;
         t_char  = (nt < l2 && nt < 32) ? b[nt] : 2'($urandom);
         if (q_valid && q_ready) nq++;
         if (t_valid && t_ready) begin
            nt++;
            last_t = up;
         end
         @(negedge clk);
         up++;
      end
      start   = 1'b0;
      q_valid = 1'b0;
      t_valid = 1'b0;
      chk({name, ":timeout"}, score_valid, 1);
      chk({name, ":score"}, score, exp_s.pop_front());
      chk({name, ":err"}, err, exp_e.pop_front());
      chk({name, ":busy"}, busy, 0);
      chk({name, ":q_hs"}, nq, norm ? l1 : 0);
      chk({name, ":t_hs"}, nt, norm ? l2 : 0);
      if (norm) chk({name, ":latency"}, up - 1 - last_t, l1);
   endtask

   initial begin #2000000; $display("FAIL watchdog expired"); $fatal(1); end

   initial begin
      logic [1:0] a[32];
      logic [1:0] b[32];
      rst_n = 1'b0;
      foreach (a[i]) begin a[i] = '0; b[i] = '0; end
      repeat (2) @(negedge clk);
      chk("rst:q_ready", q_ready, 0);
      chk("rst:t_ready", t_ready, 0);
      chk("rst:busy", busy, 0);
      chk("rst:score", score, 0);
      chk("rst:score_valid", score_valid, 0);
      chk("rst:err", err, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin a[i] = 2'(i); b[i] = 2'(i); end
      run_job("match", 4, 4, a, b, 0, 0);
      a[0] = 2'd0; a[1] = 2'd2; a[2] = 2'd3;
      run_job("gap", 3, 4, a, b, 0, 0);
      for (int i = 0; i < 4; i++) begin a[i] = 2'd0; b[i] = 2'd1; end
      run_job("mismatch", 4, 4, a, b, 0, 0);
      for (int i = 0; i < 4; i++) begin a[i] = 2'(i); b[i] = 2'(i); end
      run_job("stall", 4, 4, a, b, 1, 0);
      run_job("len1_zero", 0, 5, a, b, 0, 0);
      run_job("len2_zero", 3, 0, a, b, 0, 0);
      run_job("too_long", 9, 4, a, b, 0, 0);
      run_job("b2b_poke", 4, 4, a, b, 0, 1);
      for (int i = 0; i < 32; i++) begin a[i] = 2'($urandom); b[i] = 2'($urandom); end
      run_job("rand8x20", 8, 20, a, b, 1, 0);
      run_job("rand1x7", 1, 7, a, b, 0, 0);

      len1    = 4'd8;
      len2    = 16'd10;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      q_valid = 1'b1;
      t_valid = 1'b1;
      repeat (12) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst:q_ready", q_ready, 0);
      chk("midrst:t_ready", t_ready, 0);
      chk("midrst:busy", busy, 0);
      chk("midrst:score", score, 0);
      chk("midrst:score_valid", score_valid, 0);
      chk("midrst:err", err, 0);
      q_valid = 1'b0;
      t_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      a[0] = 2'd1; a[1] = 2'd3;
      b[0] = 2'd1; b[1] = 2'd2; b[2] = 2'd3;
      run_job("after_rst", 2, 3, a, b, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end
endmodule
